icnd2110_frame_sched: RTL and testbench
=======================================

Name: icnd2110_frame_sched

Overview:
Write-side scheduler for the double-buffered ICND2110 pixel memory: 2 × WORD_COUNT 16-bit words, two banks addressed by the MSB.
- Arbitrates pixel writes from two requesters (A = SPI host, B = animation engine) into the back bank.
- Runs a hardware fill of the back bank.
- Swaps front/back banks only at a frame boundary, signalled by the output serializer, so the LED string never shows a half-written frame.

Parameters:
WORD_COUNT, 336, words per bank (12 outputs × 28 chips)
ADDR_WIDTH, 9, pixel address width; 2^ADDR_WIDTH ≥ WORD_COUNT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
a_valid  in  1  requester A write valid
a_ready  out  1  requester A ready
a_addr  in  ADDR_WIDTH  requester A pixel address
a_data  in  16  requester A pixel value
b_valid  in  1  requester B write valid
b_ready  out  1  requester B ready
b_addr  in  ADDR_WIDTH  requester B pixel address
b_data  in  16  requester B pixel value
clear_req  in  1  single-cycle pulse: fill back bank with clear_value
clear_value  in  16  fill value, sampled with clear_req
commit_req  in  1  single-cycle pulse: swap banks at next frame end
frame_done  in  1  single-cycle pulse from serializer at end of frame-end sequence (already in clk domain)
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_WIDTH+1  {bank, pixel address}
mem_data  out  16  write data
front_bank  out  1  bank currently read by serializer
busy  out  1  high when state != IDLE or a request is pending
commit_ack  out  1  one-cycle pulse on the cycle front_bank changes
addr_err  out  1  one-cycle pulse: accepted write had addr ≥ WORD_COUNT

Behaviour:
- Clock and reset: rst is synchronous, active-high; clk is the clock. rst takes priority over every other input.
- Reset values:
  - state=IDLE; front_bank=0; mem_we=0; mem_addr=0; mem_data=0.
  - commit_ack=0; addr_err=0; clear/commit pending flags=0.
  - last_grant=B, so A wins the first tie.
- Back bank is always ~front_bank. All writes, from requesters or the fill, target the back bank.
- States: IDLE, CLEAR, COMMIT_WAIT.
- IDLE:
  - a_ready/b_ready are combinational.
  - Ready = (state==IDLE) && !clear_req && !commit_req && !clear_pend && !commit_pend && grant.
  - Grant, one requester only: if only one is valid, it is granted; if both are valid, the one not in last_grant is granted.
  - last_grant updates on every transfer.
  - A ready requester that is not valid still shows ready=1 only if granted; ungranted ready=0.
- Transfer: valid && ready at edge N. Then at edge N+1: mem_we=1, mem_addr={~front_bank, addr}, mem_data=data.
  - Latency is 1 cycle, with one write per cycle maximum.
  - If addr ≥ WORD_COUNT: the transfer still completes, mem_we stays 0, and addr_err pulses at N+1.
- clear_req seen in IDLE (or latched as clear_pend): CLEAR is entered on the next edge and the fill value is latched.
  - In CLEAR, mem_we=1 each cycle with pixel addresses 0,1,…,WORD_COUNT-1 in consecutive cycles, bank=~front_bank.
  - The fill takes exactly WORD_COUNT write cycles, then the next state is COMMIT_WAIT if commit_pend, else IDLE.
- commit_req seen in IDLE: COMMIT_WAIT is entered on the next edge.
- Requests arriving in other states:
  - commit_req while in CLEAR: sets commit_pend.
  - clear_req while in CLEAR: ignored.
  - clear_req while in COMMIT_WAIT: sets clear_pend, serviced after the swap.
  - commit_req while in COMMIT_WAIT: ignored.
- clear_req and commit_req in the same IDLE cycle: clear runs first, then commit.
- COMMIT_WAIT:
  - Ready=0 for both requesters; mem_we=0.
  - On the first cycle with frame_done=1: front_bank toggles, commit_ack=1 for one cycle, commit_pend clears, state→IDLE (or →CLEAR if clear_pend).
- frame_done outside COMMIT_WAIT is ignored.
- A frame_done in the same cycle commit_req is sampled in IDLE does not count; a later frame_done is required.
- Reset mid-CLEAR or mid-COMMIT_WAIT aborts: there is no swap, a partial fill is left as-is, and all pending flags clear.
- busy=1 whenever state != IDLE or clear_pend or commit_pend.

Test Plan:
- Reset then A writes addr 5, data 0x1234 → next cycle mem_we=1, mem_addr={1,5}, mem_data=0x1234, front_bank=0.
- A and B both valid continuously with addrs 1/2 → grants alternate A,B,A,B; exactly one mem_we per cycle with no gaps.
- clear_req, clear_value=0x00FF → mem_we high 336 consecutive cycles, addresses {1,0}…{1,335}; ready=0 throughout; IDLE afterwards.
- commit_req, then frame_done 50 cycles later → ready=0 for 50 cycles; front_bank 0→1 with a 1-cycle commit_ack; next A write goes to bank 0.
- clear_req and commit_req together, frame_done pulsed mid-clear and again after it → mid-clear pulse ignored; swap on the post-clear pulse only.
- B write to addr 400 → addr_err pulse, mem_we=0; rst asserted at clear word 100 → mem_we=0 next cycle, front_bank=0, busy=0.

Source files
------------

// File: rtl/icnd2110_frame_sched.sv
// Write-side scheduler for the double-buffered ICND2110 pixel memory: arbitrates two pixel
// writers into the back bank, runs bank fills and swaps banks only at serializer frame end.
module icnd2110_frame_sched #(
  parameter int unsigned WORD_COUNT = 336,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [15:0]           a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [15:0]           b_data,
  input  logic                  clear_req,
  input  logic [15:0]           clear_value,
  input  logic                  commit_req,
  input  logic                  frame_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [15:0]           mem_data,
  output logic                  front_bank,
  output logic                  busy,
  output logic                  commit_ack,
  output logic                  addr_err
);

  typedef enum logic [1:0] {StIdle, StClear, StCommitWait} state_e;

  // One bit wider than the pixel address so WORD_COUNT == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   WordLim  = (ADDR_WIDTH+1)'(WORD_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(WORD_COUNT - 1);

  state_e                state_q, state_d;
  logic                  front_bank_q, front_bank_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic [15:0]           mem_data_q, mem_data_d;
  logic                  commit_ack_q, commit_ack_d;
  logic                  addr_err_q, addr_err_d;
  logic                  clear_pend_q, clear_pend_d;
  logic                  commit_pend_q, commit_pend_d;
  logic                  last_grant_b_q, last_grant_b_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [15:0]           fill_val_q, fill_val_d;

  logic                  idle_open, grant_a, xfer_a, xfer_b;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           sel_data;

  always_comb begin
    idle_open = (state_q == StIdle) && !clear_req && !commit_req && !clear_pend_q &&
                !commit_pend_q;
    // A lone valid requester wins; on a tie (or idle) the one not served last is offered.
    grant_a   = (a_valid && !b_valid) || ((a_valid == b_valid) && last_grant_b_q);
    a_ready   = idle_open && grant_a;
    b_ready   = idle_open && !grant_a;
    xfer_a    = a_valid && a_ready;
    xfer_b    = b_valid && b_ready;
    sel_addr  = xfer_a ? a_addr : b_addr;
    sel_data  = xfer_a ? a_data : b_data;
  end

  always_comb begin
    state_d        = state_q;
    front_bank_d   = front_bank_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    commit_ack_d   = 1'b0;
    addr_err_d     = 1'b0;
    clear_pend_d   = clear_pend_q;
    commit_pend_d  = commit_pend_q;
    last_grant_b_d = last_grant_b_q;
    fill_cnt_d     = fill_cnt_q;
    fill_val_d     = fill_val_q;

    unique case (state_q)
      StIdle: begin
        if (xfer_a || xfer_b) begin
          last_grant_b_d = xfer_b;
          if ({1'b0, sel_addr} < WordLim) begin
            mem_we_d   = 1'b1;
            mem_addr_d = {~front_bank_q, sel_addr};
            mem_data_d = sel_data;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (clear_req || clear_pend_q) begin
          state_d      = StClear;
          fill_cnt_d   = '0;
          clear_pend_d = 1'b0;
          if (clear_req) fill_val_d = clear_value;
          if (commit_req) commit_pend_d = 1'b1;
        end else if (commit_req || commit_pend_q) begin
          state_d = StCommitWait;
        end
      end

      StClear: begin
        mem_we_d   = 1'b1;
        mem_addr_d = {~front_bank_q, fill_cnt_q};
        mem_data_d = fill_val_q;
        fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
        if (commit_req) commit_pend_d = 1'b1;
        if (fill_cnt_q == LastWord) begin
          state_d = (commit_pend_q || commit_req) ? StCommitWait : StIdle;
        end
      end

      StCommitWait: begin
        if (clear_req) begin
          clear_pend_d = 1'b1;
          fill_val_d   = clear_value;
        end
        if (frame_done) begin
          front_bank_d  = ~front_bank_q;
          commit_ack_d  = 1'b1;
          commit_pend_d = 1'b0;
          if (clear_pend_q || clear_req) begin
            state_d      = StClear;
            fill_cnt_d   = '0;
            clear_pend_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      front_bank_q   <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      commit_ack_q   <= 1'b0;
      addr_err_q     <= 1'b0;
      clear_pend_q   <= 1'b0;
      commit_pend_q  <= 1'b0;
      last_grant_b_q <= 1'b1;
      fill_cnt_q     <= '0;
      fill_val_q     <= '0;
    end else begin
      state_q        <= state_d;
      front_bank_q   <= front_bank_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      commit_ack_q   <= commit_ack_d;
      addr_err_q     <= addr_err_d;
      clear_pend_q   <= clear_pend_d;
      commit_pend_q  <= commit_pend_d;
      last_grant_b_q <= last_grant_b_d;
      fill_cnt_q     <= fill_cnt_d;
      fill_val_q     <= fill_val_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign front_bank = front_bank_q;
  assign commit_ack = commit_ack_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q != StIdle) || clear_pend_q || commit_pend_q;

endmodule

// File: tb/tb_icnd2110_frame_sched.sv
// Directed bench for icnd2110_frame_sched: a vector table for arbitration and address checks,
// plus hand-written clear, commit, combined clear+commit and reset-abort sequences.
module tb_icnd2110_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data, clear_value, mem_data;
  logic        clear_req, commit_req, frame_done;
  logic        mem_we, front_bank, busy, commit_ack, addr_err;
  logic [9:0]  mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icnd2110_frame_sched #(.WORD_COUNT(336), .ADDR_WIDTH(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .clear_req  (clear_req),
    .clear_value(clear_value),
    .commit_req (commit_req),
    .frame_done (frame_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .front_bank (front_bank),
    .busy       (busy),
    .commit_ack (commit_ack),
    .addr_err   (addr_err)
  );

  typedef struct {
    logic        av;
    logic [8:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [8:0]  ba;
    logic [15:0] bd;
    logic        chk_rdy;
    logic        ar;
    logic        br;
    logic        we;
    logic [9:0]  ma;
    logic [15:0] md;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    clear_req = 0; clear_value = 0; commit_req = 0; frame_done = 0;

    //          av  aa    ad       bv  ba    bd       chk ar br we ma      md       err
    vecs[0] = '{1, 9'd5,   16'h1234, 1, 9'd2,   16'h2222, 1, 1, 0, 1, 10'h205, 16'h1234, 0};
    vecs[1] = '{1, 9'd1,   16'h1111, 1, 9'd2,   16'h2222, 1, 0, 1, 1, 10'h202, 16'h2222, 0};
    vecs[2] = '{1, 9'd1,   16'h1111, 1, 9'd2,   16'h2222, 1, 1, 0, 1, 10'h201, 16'h1111, 0};
    vecs[3] = '{1, 9'd1,   16'h1111, 1, 9'd2,   16'h2222, 1, 0, 1, 1, 10'h202, 16'h2222, 0};
    vecs[4] = '{0, 9'd0,   16'h0000, 1, 9'd400, 16'hBEEF, 1, 0, 1, 0, 10'h000, 16'h0000, 1};
    vecs[5] = '{0, 9'd0,   16'h0000, 0, 9'd0,   16'h0000, 0, 0, 0, 0, 10'h000, 16'h0000, 0};
    vecs[6] = '{0, 9'd0,   16'h0000, 1, 9'd335, 16'h0335, 1, 0, 1, 1, 10'h34F, 16'h0335, 0};
    vecs[7] = '{1, 9'd336, 16'hDEAD, 0, 9'd0,   16'h0000, 1, 1, 0, 0, 10'h000, 16'h0000, 1};
    vecs[8] = '{1, 9'd0,   16'hAAAA, 0, 9'd0,   16'h0000, 1, 1, 0, 1, 10'h200, 16'hAAAA, 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_front_bank", front_bank, 0);
    check("rst_busy", busy, 0);
    check("rst_commit_ack", commit_ack, 0);
    check("rst_addr_err", addr_err, 0);

    // Arbitration and address-range vectors.
    for (int i = 0; i < 9; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      if (vecs[i].chk_rdy) begin
        check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ar);
        check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].br);
      end
      tick();
      check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we);
      check($sformatf("v%0d_addr_err", i), addr_err, vecs[i].err);
      if (vecs[i].we) begin
        check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ma);
        check($sformatf("v%0d_mem_data", i), mem_data, vecs[i].md);
      end
    end
    b_valid = 0;

    // Clear of back bank 1 with A holding a request the whole time.
    a_valid = 1; a_addr = 9'd3; a_data = 16'h3333;
    clear_req = 1; clear_value = 16'h00FF;
    #1;
    check("clr_req_a_ready", a_ready, 0);
    tick();
    clear_req = 0; clear_value = 16'h0000;
    check("clr_start_mem_we", mem_we, 0);
    check("clr_start_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 336; i++) begin
      if (a_ready !== 1'b0) bad++;
      tick();
      if (mem_we !== 1'b1 || mem_addr !== 10'(10'h200 + i) || mem_data !== 16'h00FF) bad++;
    end
    check("clr_bad_cycles", bad, 0);
    check("clr_end_busy", busy, 0);
    check("clr_end_a_ready", a_ready, 1);
    a_valid = 0;
    tick();
    check("clr_no_extra_we", mem_we, 0);

    // Commit with frame_done 50 cycles after the request.
    a_valid = 1; a_addr = 9'd7; a_data = 16'h7777;
    commit_req = 1;
    #1;
    check("cmt_req_a_ready", a_ready, 0);
    tick();
    commit_req = 0;
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      if (a_ready !== 1'b0 || mem_we !== 1'b0 || front_bank !== 1'b0 || commit_ack !== 1'b0)
        bad++;
      tick();
    end
    frame_done = 1;
    #1;
    if (a_ready !== 1'b0 || front_bank !== 1'b0) bad++;
    check("cmt_wait_bad_cycles", bad, 0);
    tick();
    frame_done = 0;
    check("cmt_front_bank", front_bank, 1);
    check("cmt_ack", commit_ack, 1);
    check("cmt_busy", busy, 0);
    check("cmt_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    check("cmt_ack_pulse", commit_ack, 0);
    check("cmt_wr_we", mem_we, 1);
    check("cmt_wr_addr", mem_addr, 10'h007);
    check("cmt_wr_data", mem_data, 16'h7777);

    // Clear and commit together; the frame_done during the fill must not swap.
    clear_req = 1; commit_req = 1; clear_value = 16'h5A5A;
    tick();
    clear_req = 0; commit_req = 0;
    bad = 0;
    for (int i = 0; i < 336; i++) begin
      frame_done = (i == 100);
      tick();
      frame_done = 0;
      if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_data !== 16'h5A5A) bad++;
      if (front_bank !== 1'b1 || commit_ack !== 1'b0) bad++;
    end
    check("cc_fill_bad_cycles", bad, 0);
    repeat (3) tick();
    check("cc_wait_busy", busy, 1);
    check("cc_wait_front", front_bank, 1);
    check("cc_wait_we", mem_we, 0);
    frame_done = 1;
    tick();
    frame_done = 0;
    check("cc_swap_front", front_bank, 0);
    check("cc_swap_ack", commit_ack, 1);
    check("cc_swap_busy", busy, 0);
    tick();
    check("cc_ack_pulse", commit_ack, 0);

    // Swap to front 1, then reset in the middle of a clear.
    commit_req = 1;
    tick();
    commit_req = 0;
    frame_done = 1;
    tick();
    frame_done = 0;
    check("rs_pre_front", front_bank, 1);
    check("rs_pre_ack", commit_ack, 1);
    clear_req = 1; clear_value = 16'h1111;
    tick();
    clear_req = 0;
    repeat (100) tick();
    check("rs_word99_addr", mem_addr, 10'h063);
    check("rs_word99_we", mem_we, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rs_mem_we", mem_we, 0);
    check("rs_front", front_bank, 0);
    check("rs_busy", busy, 0);
    check("rs_mem_addr", mem_addr, 0);
    tick();
    check("rs_no_resume_we", mem_we, 0);
    check("rs_no_resume_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
